// File: rtl/seq_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_gen
// Description : Serial bit-pattern transmitter. Captures a 1..PAT_W bit
//               pattern and shifts it out MSB-first, one bit per clock, with
//               repeated passes, an optional idle gap between passes and a
//               synchronous abort. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  input  logic             abort,
  output logic             x,
  output logic             x_vld,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [LEN_W-1:0] c_pat_w   = LEN_W'(PAT_W);
  localparam logic [PAT_W-1:0] c_pat_one = PAT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] gap_cfg_q, gap_cfg_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_vld_q, x_vld_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic w_len_ok;
  logic w_first_in_bit;
  logic w_first_q_bit;
  logic w_next_bit;

  // Bit selection is done with a mask rather than a variable index so the
  // index width never has to match the pattern width exactly.
  assign w_len_ok       = (len != '0) && (len <= c_pat_w);
  assign w_first_in_bit = |(pat   & (c_pat_one << (len   - c_len_one)));
  assign w_first_q_bit  = |(pat_q & (c_pat_one << (len_q - c_len_one)));
  // When bit_q is 0 the shift runs off the top and yields 0; that value is
  // never used because the pass-end branch takes over.
  assign w_next_bit     = |(pat_q & (c_pat_one << (bit_q - c_len_one)));

  // Next-state and next-output computation for the IDLE/SHIFT/GAP sequencer.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    bit_d     = bit_q;
    pass_d    = pass_q;
    gap_cfg_d = gap_cfg_q;
    gap_cnt_d = gap_cnt_q;
    x_d       = 1'b0;
    x_vld_d   = 1'b0;
    last_d    = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      // Cancel: all outputs drop via the defaults, no done pulse.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // abort in IDLE does nothing on its own but still wins over start.
          if (start && !abort) begin
            if (w_len_ok) begin
              pat_d     = pat;
              len_d     = len;
              pass_d    = reps;
              gap_cfg_d = gap;
              bit_d     = len - c_len_one;
              state_d   = S_SHIFT;
              x_d       = w_first_in_bit;
              x_vld_d   = 1'b1;
              last_d    = (len == c_len_one);
              busy_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        S_SHIFT: begin
          if (bit_q != '0) begin
            bit_d   = bit_q - c_len_one;
            x_d     = w_next_bit;
            x_vld_d = 1'b1;
            last_d  = (bit_q == c_len_one);
            busy_d  = 1'b1;
          end else if (pass_q != '0) begin
            pass_d = pass_q - c_cnt_one;
            busy_d = 1'b1;
            if (gap_cfg_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_cfg_q;
            end else begin
              // Back-to-back pass: first bit follows with no bubble.
              bit_d   = len_q - c_len_one;
              x_d     = w_first_q_bit;
              x_vld_d = 1'b1;
              last_d  = (len_q == c_len_one);
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end

        S_GAP: begin
          busy_d = 1'b1;
          if (gap_cnt_q == c_cnt_one) begin
            state_d = S_SHIFT;
            bit_d   = len_q - c_len_one;
            x_d     = w_first_q_bit;
            x_vld_d = 1'b1;
            last_d  = (len_q == c_len_one);
          end else begin
            gap_cnt_d = gap_cnt_q - c_cnt_one;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, captured configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      pass_q    <= '0;
      gap_cfg_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      x_vld_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      pass_q    <= pass_d;
      gap_cfg_q <= gap_cfg_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_vld_q   <= x_vld_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign x     = x_q;
  assign x_vld = x_vld_q;
  assign last  = last_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule
`default_nettype wire

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter: the generating end of the serial "x" stream that the team's Mealy sequence detectors consume. It loads a programmable pattern of 1..PAT_W bits and shifts it out MSB-first, one bit per clock. It supports repeated passes, an optional idle gap between passes, and an abort input. It is used as on-chip stimulus and loopback source for detector blocks such as the 101 detector.

Parameters:
PAT_W, 8, maximum pattern length in bits.
LEN_W, 4, width of len; must satisfy 2^LEN_W > PAT_W.
CNT_W, 4, width of the reps and gap counters.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  request; sampled only when busy==0.
pat  in  PAT_W  pattern; bit len-1 is sent first, bit 0 last.
len  in  LEN_W  number of pattern bits, legal range 1..PAT_W.
reps  in  CNT_W  extra passes; total passes = reps+1.
gap  in  CNT_W  idle cycles inserted between passes; 0 gives back-to-back passes.
abort  in  1  synchronous cancel.
x  out  1  serial data bit.
x_vld  out  1  x is a valid pattern bit this cycle.
last  out  1  high with the final bit of each pass.
busy  out  1  transfer in progress.
done  out  1  one-cycle pulse on normal completion.
err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset and registration
  - Asynchronous reset (rst=0) forces state IDLE and all outputs to 0: x, x_vld, last, busy, done, err.
  - All outputs are registered; no output is combinational from any input.
  - Reset asserted mid-transfer aborts immediately, with no done pulse.
- States: IDLE, SHIFT, GAP.
- IDLE, start=1 with legal len
  - Capture pat, len, reps and gap into internal registers.
  - Next edge: state=SHIFT, busy=1, x_vld=1, x=pat[len-1]. Latency from start to the first bit is 1 cycle.
- IDLE, start=1 with len==0 or len>PAT_W
  - Nothing is captured; state stays IDLE.
  - err=1 for exactly one cycle.
- SHIFT
  - Each cycle presents the next lower bit.
  - On the cycle showing bit 0 of a pass, last=1.
  - After that cycle:
    - if passes remain and gap>0: go to GAP;
    - if passes remain and gap==0: stay in SHIFT and present bit len-1 of the next pass in the very next cycle, with no bubble;
    - if no passes remain: go to IDLE.
- GAP
  - x=0, x_vld=0, last=0, busy=1 for exactly gap cycles, then SHIFT starting with bit len-1.
- Completion
  - In the cycle after the final bit: done=1 for one cycle, busy=0, x_vld=0, x=0, last=0, state IDLE.
  - A start in that done cycle is accepted, so a new first bit appears on the following cycle.
- Inputs while busy
  - start while busy=1 is ignored and does not raise err.
  - pat, len, reps and gap changes while busy=1 have no effect; the captured copies are used.
- abort
  - abort=1 in any state: next edge returns to IDLE with x_vld=0, busy=0, last=0, x=0, and no done.
  - abort takes priority over start in the same cycle.
  - abort while IDLE has no effect.
- Invariants
  - When x_vld=0, x is 0.
  - last=1 only when x_vld=1.
  - Total valid cycles per transfer = len*(reps+1).
  - Total busy cycles = len*(reps+1) + gap*reps.
- Counters: bit index counts down from len-1 to 0; the pass counter counts down from reps to 0; the gap counter counts down from gap to 1. There is no wrap-around beyond these ranges.

Test Plan:
- pat=8'b0000_0101, len=3, reps=0, gap=0, start pulse -> x_vld=1 for 3 cycles with x=1,0,1; last on the 3rd; done on the 4th; busy high for exactly 3 cycles.
- Same pattern with reps=2, gap=0, output fed to the 101 overlapping detector -> 9 contiguous valid bits 101101101; last at bits 3, 6 and 9; detector output y=1 three times.
- pat=101, reps=1, gap=2 -> 1,0,1, then 2 cycles with x_vld=0 and busy=1, then 1,0,1, then done; 8 busy cycles in total.
- start with len=0, and separately len=9 -> err pulses once per request, busy stays 0, x_vld stays 0, no done.
- pat=8'hA5, len=8, abort raised at the 4th bit -> next cycle x_vld=0 and busy=0, no done. A fresh start is then accepted normally; a start asserted together with abort is dropped.
- rst driven low mid-pass -> all outputs are 0 immediately. After release, start produces a correct full transfer, and start pulses held during busy produce no second transfer.
